// File: rtl/input_cond_pkg.sv
// Shared encodings and widths for the input conditioner and its debounce FSM.
package input_cond_pkg;

    localparam int unsigned STATE_SIZE      = 2;
    localparam int unsigned EVENT_CNT_WIDTH = 8;

    typedef enum logic [STATE_SIZE-1:0] {
        STABLE_LOW  = 2'b00,
        CHECK_HIGH  = 2'b01,
        STABLE_HIGH = 2'b10,
        CHECK_LOW   = 2'b11
    } state_e;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous input; reset clears every stage.
module sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stages_q <= '0;
        end else begin
            stages_q <= {stages_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces raw_in, emitting one-cycle pulses on qualified edges
// for the downstream pulse-counting FSM.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          PULSE_ON_RISE   = 1'b1,
    parameter bit          PULSE_ON_FALL   = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       raw_in,
    input  logic                       en,
    output logic                       level_out,
    output logic                       pulse_out,
    output logic [EVENT_CNT_WIDTH-1:0] event_count
);

    localparam int unsigned CNT_LOG   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned CNT_WIDTH = (CNT_LOG < 1) ? 1 : CNT_LOG;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                       sync_in;
    state_e                     state_q, state_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic                       level_q, level_d;
    logic                       pulse_q, pulse_d;
    logic [EVENT_CNT_WIDTH-1:0] count_q, count_d;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (raw_in),
        .q    (sync_in)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        count_d = count_q;
        if (en) begin
            unique case (state_q)
                STABLE_LOW: begin
                    if (sync_in) begin
                        state_d = CHECK_HIGH;
                        cnt_d   = '0;
                    end
                end
                CHECK_HIGH: begin
                    if (!sync_in) begin
                        state_d = STABLE_LOW;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = STABLE_HIGH;
                        level_d = 1'b1;
                        pulse_d = PULSE_ON_RISE;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                STABLE_HIGH: begin
                    if (!sync_in) begin
                        state_d = CHECK_LOW;
                        cnt_d   = '0;
                    end
                end
                CHECK_LOW: begin
                    if (sync_in) begin
                        state_d = STABLE_HIGH;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = STABLE_LOW;
                        level_d = 1'b0;
                        pulse_d = PULSE_ON_FALL;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: state_d = STABLE_LOW;
            endcase
        end
        // Event count advances on the same edge that registers the pulse.
        if (pulse_d) begin
            count_d = count_q + EVENT_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            count_q <= count_d;
        end
    end

    assign level_out   = level_q;
    assign pulse_out   = pulse_q;
    assign event_count = count_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: a rise-pulsing and a fall-pulsing instance share stimulus.
module tb_input_conditioner;
    import input_cond_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       raw_in = 1'b0;
    logic       en = 1'b1;
    logic       level_out, pulse_out;
    logic [7:0] event_count;
    logic       level_f, pulse_f;
    logic [7:0] count_f;

    int checks = 0;
    int fails = 0;
    int pulses = 0;
    int pulses_f = 0;
    logic prev_pulse = 1'b0;
    logic prev_pulse_f = 1'b0;

    always #5 clk = ~clk;

    input_conditioner dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .en         (en),
        .level_out  (level_out),
        .pulse_out  (pulse_out),
        .event_count(event_count)
    );

    input_conditioner #(
        .PULSE_ON_RISE(1'b0),
        .PULSE_ON_FALL(1'b1)
    ) dut_f (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .en         (en),
        .level_out  (level_f),
        .pulse_out  (pulse_f),
        .event_count(count_f)
    );

    // One clock edge, then sample 1 time unit later; also guards against back-to-back pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pulse_out) begin
            pulses++;
            checks++;
            if (prev_pulse) begin
                fails++;
                $display("FAIL back_to_back: pulse_out high two cycles in a row at %0t", $time);
            end
        end
        if (pulse_f) begin
            pulses_f++;
            checks++;
            if (prev_pulse_f) begin
                fails++;
                $display("FAIL back_to_back_f: pulse_out high two cycles in a row at %0t", $time);
            end
        end
        prev_pulse   = pulse_out;
        prev_pulse_f = pulse_f;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        raw_in = 1'b0;
        en     = 1'b1;
        ticks(2);
        reset    = 1'b0;
        pulses   = 0;
        pulses_f = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({level_out, pulse_out, event_count} !== 10'd0 || dut.state_q !== STABLE_LOW) begin
            fails++;
            $display("FAIL reset_state: level=%b pulse=%b count=%0d state=%0d, want 0 0 0 0",
                     level_out, pulse_out, event_count, dut.state_q);
        end
    endtask

    task automatic test_rise();
        do_reset();
        raw_in = 1'b1;
        ticks(6);
        checks++;
        if (level_out !== 1'b0 || pulse_out !== 1'b0) begin
            fails++;
            $display("FAIL rise_edge6: level=%b pulse=%b, want 0 0", level_out, pulse_out);
        end
        tick();
        checks++;
        if (level_out !== 1'b1 || pulse_out !== 1'b1 || event_count !== 8'd1) begin
            fails++;
            $display("FAIL rise_edge7: level=%b pulse=%b count=%0d, want 1 1 1",
                     level_out, pulse_out, event_count);
        end
        tick();
        checks++;
        if (level_out !== 1'b1 || pulse_out !== 1'b0 || event_count !== 8'd1) begin
            fails++;
            $display("FAIL rise_edge8: level=%b pulse=%b count=%0d, want 1 0 1",
                     level_out, pulse_out, event_count);
        end
    endtask

    task automatic test_glitch_four();
        do_reset();
        raw_in = 1'b1;
        ticks(4);
        raw_in = 1'b0;
        ticks(2);
        checks++;
        if (dut.state_q !== CHECK_HIGH) begin
            fails++;
            $display("FAIL glitch_checking: state=%0d, want %0d", dut.state_q, CHECK_HIGH);
        end
        ticks(10);
        checks++;
        if (level_out !== 1'b0 || event_count !== 8'd0 || pulses != 0 ||
            dut.state_q !== STABLE_LOW) begin
            fails++;
            $display("FAIL glitch_four: level=%b count=%0d pulses=%0d state=%0d, want 0 0 0 0",
                     level_out, event_count, pulses, dut.state_q);
        end
    endtask

    task automatic test_five_samples();
        do_reset();
        raw_in = 1'b1;
        ticks(5);
        raw_in = 1'b0;
        ticks(2);
        checks++;
        if (pulse_out !== 1'b1 || level_out !== 1'b1 || event_count !== 8'd1) begin
            fails++;
            $display("FAIL five_qualify: pulse=%b level=%b count=%0d, want 1 1 1",
                     pulse_out, level_out, event_count);
        end
        ticks(12);
        checks++;
        if (level_out !== 1'b0 || event_count !== 8'd1 || pulses != 1) begin
            fails++;
            $display("FAIL five_fall: level=%b count=%0d pulses=%0d, want 0 1 1",
                     level_out, event_count, pulses);
        end
    endtask

    task automatic test_fall_pulse();
        do_reset();
        raw_in = 1'b1;
        ticks(10);
        checks++;
        if (level_f !== 1'b1 || pulses_f != 0 || count_f !== 8'd0) begin
            fails++;
            $display("FAIL fall_after_rise: level=%b pulses=%0d count=%0d, want 1 0 0",
                     level_f, pulses_f, count_f);
        end
        raw_in = 1'b0;
        ticks(7);
        checks++;
        if (pulse_f !== 1'b1 || level_f !== 1'b0 || count_f !== 8'd1) begin
            fails++;
            $display("FAIL fall_edge7: pulse=%b level=%b count=%0d, want 1 0 1",
                     pulse_f, level_f, count_f);
        end
        ticks(3);
        checks++;
        if (pulses_f != 1 || count_f !== 8'd1) begin
            fails++;
            $display("FAIL fall_total: pulses=%0d count=%0d, want 1 1", pulses_f, count_f);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        raw_in = 1'b1;
        ticks(5);
        checks++;
        if (dut.state_q !== CHECK_HIGH || dut.cnt_q !== 2'd2) begin
            fails++;
            $display("FAIL mid_setup: state=%0d cnt=%0d, want %0d 2",
                     dut.state_q, dut.cnt_q, CHECK_HIGH);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({level_out, pulse_out, event_count} !== 10'd0 || dut.state_q !== STABLE_LOW ||
            dut.cnt_q !== 2'd0) begin
            fails++;
            $display("FAIL mid_async: level=%b pulse=%b count=%0d state=%0d, want all 0",
                     level_out, pulse_out, event_count, dut.state_q);
        end
        tick();
        reset  = 1'b0;
        pulses = 0;
        ticks(6);
        checks++;
        if (pulse_out !== 1'b0 || level_out !== 1'b0) begin
            fails++;
            $display("FAIL mid_early: pulse=%b level=%b, want 0 0", pulse_out, level_out);
        end
        tick();
        checks++;
        if (pulse_out !== 1'b1 || event_count !== 8'd1) begin
            fails++;
            $display("FAIL mid_relatency: pulse=%b count=%0d, want 1 1", pulse_out, event_count);
        end
    endtask

    task automatic test_wrap_enable();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            raw_in = 1'b1;
            ticks(8);
            raw_in = 1'b0;
            ticks(8);
            if (i == 254) begin
                checks++;
                if (event_count !== 8'd255) begin
                    fails++;
                    $display("FAIL count_255: count=%0d, want 255", event_count);
                end
            end
        end
        checks++;
        if (event_count !== 8'd0 || pulses != 256) begin
            fails++;
            $display("FAIL count_wrap: count=%0d pulses=%0d, want 0 256", event_count, pulses);
        end
        en     = 1'b0;
        raw_in = 1'b1;
        pulses = 0;
        ticks(12);
        checks++;
        if (pulses != 0 || level_out !== 1'b0 || event_count !== 8'd0 ||
            dut.state_q !== STABLE_LOW) begin
            fails++;
            $display("FAIL en_hold: pulses=%0d level=%b count=%0d state=%0d, want 0 0 0 0",
                     pulses, level_out, event_count, dut.state_q);
        end
        en = 1'b1;
        ticks(4);
        checks++;
        if (pulse_out !== 1'b0 || level_out !== 1'b0) begin
            fails++;
            $display("FAIL en_resume_early: pulse=%b level=%b, want 0 0", pulse_out, level_out);
        end
        tick();
        checks++;
        if (pulse_out !== 1'b1 || level_out !== 1'b1 || event_count !== 8'd1) begin
            fails++;
            $display("FAIL en_resume: pulse=%b level=%b count=%0d, want 1 1 1",
                     pulse_out, level_out, event_count);
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_glitch_four();
        test_five_samples();
        test_fall_pulse();
        test_reset_mid();
        test_wrap_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
